// File: rtl/div_pkg.sv
// Shared types and constants for the M-extension divide front end.
// Holds the op encoding, the FSM state set and the special-case constants.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } div_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/div_special_detect.sv
// Flags operand pairs the core must not see: divide by zero and signed overflow.
// Ports: op_i, a_i, b_i in; is_special_o, special_result_o out (combinational).
module div_special_detect
  import div_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        is_special_o,
  output logic [31:0] special_result_o
);

  div_op_e op;
  logic    b_zero;
  logic    ovf;

  assign op     = div_op_e'(op_i);
  assign b_zero = (b_i == 32'd0);
  // INT_MIN / -1 only overflows for the signed variants
  assign ovf    = (op == OP_DIV || op == OP_REM) &&
                  (a_i == INT_MIN) && (b_i == 32'hFFFF_FFFF);

  always_comb begin
    is_special_o     = b_zero | ovf;
    special_result_o = 32'd0;
    if (b_zero) begin
      special_result_o = (op == OP_DIV || op == OP_DIVU) ? DIV0_QUOT : a_i;
    end else if (ovf) begin
      special_result_o = (op == OP_DIV) ? INT_MIN : 32'd0;
    end
  end

endmodule

// File: rtl/div_op_frontend.sv
// DIV/DIVU/REM/REMU front end: sign handling and special cases around an
// unsigned core. Ports: in_* request, core_* core req/rsp, out_* result.
module div_op_frontend
  import div_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             core_valid,
  input  logic             core_ready,
  output logic [31:0]      core_dividend,
  output logic [31:0]      core_divisor,
  input  logic             core_rsp_valid,
  output logic             core_rsp_ready,
  input  logic [31:0]      core_quotient,
  input  logic [31:0]      core_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [31:0]      dvd_q, dvd_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [31:0]      res_q, res_d;

  div_op_e     in_op_e;
  logic        signed_op;
  logic        is_special;
  logic [31:0] special_result;

  assign in_op_e   = div_op_e'(in_op);
  assign signed_op = (in_op_e == OP_DIV) || (in_op_e == OP_REM);

  div_special_detect u_special (
    .op_i             (in_op),
    .a_i              (in_a),
    .b_i              (in_b),
    .is_special_o     (is_special),
    .special_result_o (special_result)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = in_op_e;
          tag_d = in_tag;
          sa_d  = in_a[31] & signed_op;
          sb_d  = in_b[31] & signed_op;
          // negating INT_MIN wraps back to INT_MIN, its own magnitude
          dvd_d = sa_d ? (~in_a + 32'd1) : in_a;
          dvs_d = sb_d ? (~in_b + 32'd1) : in_b;
          if (is_special) begin
            res_d   = special_result;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (core_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_rsp_valid) begin
          if (op_q == OP_DIV || op_q == OP_DIVU) begin
            res_d = (sa_q ^ sb_q) ? (~core_quotient + 32'd1) : core_quotient;
          end else begin
            // remainder takes the dividend's sign
            res_d = sa_q ? (~core_remainder + 32'd1) : core_remainder;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_DIV;
      tag_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
    end
  end

  // held low while reset is asserted so nothing is taken during reset
  assign in_ready       = (state_q == S_IDLE) & ~rst;
  assign core_valid     = (state_q == S_ISSUE);
  assign core_rsp_ready = (state_q == S_WAIT);
  assign out_valid      = (state_q == S_RESP);
  assign core_dividend  = dvd_q;
  assign core_divisor   = dvs_q;
  assign out_result     = res_q;
  assign out_tag        = tag_q;

endmodule

// File: tb/tb_div_op_frontend.sv
// Scoreboard bench for div_op_frontend with a behavioural divider core.
// Directed corner cases, backpressure, mid-op reset, then random traffic.
module tb_div_op_frontend;

  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        core_valid;
  logic        core_ready = 1'b0;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_rsp_valid = 1'b0;
  logic        core_rsp_ready;
  logic [31:0] core_quotient = 32'd0;
  logic [31:0] core_remainder = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  logic [36:0] exp_q[$];
  logic [63:0] mag_q[$];

  bit stall_req = 1'b0;
  bit hold_out  = 1'b0;
  int lat_cfg   = -1;

  always #5 clk = ~clk;

  div_op_frontend #(.TAG_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_tag         (in_tag),
    .core_valid     (core_valid),
    .core_ready     (core_ready),
    .core_dividend  (core_dividend),
    .core_divisor   (core_divisor),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_ready (core_rsp_ready),
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_tag        (out_tag)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Architectural RISC-V M-extension results computed with plain arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        return 32'(sa / sb);
      end
      2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_spec(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    return (b == 0) ||
           (!op[0] && a == MINV && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] mag(input logic [1:0] op,
                                      input logic [31:0] x);
    return (!op[0] && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return MINV;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Holds the request until the DUT takes it, then queues the expectations
  task automatic send(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({tag, ref_res(op, a, b)});
        if (!is_spec(op, a, b)) mag_q.push_back({mag(op, a), mag(op, b)});
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 500) begin
        fail_now("accept_timeout");
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  // One directed op with first-cycle latency check
  task automatic run(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] tag);
    send(op, a, b, tag);
    @(negedge clk);
    if (is_spec(op, a, b)) begin
      check("spec_out_valid_c1", 64'(out_valid), 64'd1);
      check("spec_core_idle", 64'(core_valid), 64'd0);
    end else begin
      check("core_valid_c1", 64'(core_valid), 64'd1);
      check("norm_out_idle", 64'(out_valid), 64'd0);
    end
    drain();
  endtask

  task automatic wait_neg(input string name, ref logic sig);
    int n;
    n = 0;
    @(negedge clk);
    while (!sig && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sig) fail_now(name);
  endtask

  // Behavioural unsigned divider core with random or fixed latency
  logic [31:0] cm_q;
  logic [31:0] cm_r;
  int          cm_cnt;
  bit          cm_busy = 1'b0;
  always begin : core_model
    bit r;
    bit hq;
    bit hr;
    logic [63:0] m;
    @(negedge clk);
    r  = rst;
    hq = core_valid && core_ready;
    hr = core_rsp_valid && core_rsp_ready;
    if (!r && hq) begin
      if (mag_q.size() == 0) begin
        fail_now("core_unexpected_req");
      end else begin
        m = mag_q.pop_front();
        check("core_dividend", 64'(core_dividend), 64'(m[63:32]));
        check("core_divisor", 64'(core_divisor), 64'(m[31:0]));
      end
      cm_q = (core_divisor == 0) ? 32'hFFFF_FFFF : core_dividend / core_divisor;
      cm_r = (core_divisor == 0) ? core_dividend : core_dividend % core_divisor;
    end
    @(posedge clk);
    #1;
    if (r) begin
      cm_busy        = 1'b0;
      core_rsp_valid = 1'b0;
      core_ready     = 1'b0;
    end else begin
      if (hr) begin
        core_rsp_valid = 1'b0;
        cm_busy        = 1'b0;
      end
      if (hq) begin
        cm_busy    = 1'b1;
        core_ready = 1'b0;
        cm_cnt     = (lat_cfg < 0) ? $urandom_range(0, 4) : lat_cfg;
      end else if (cm_busy && !core_rsp_valid) begin
        if (cm_cnt == 0) begin
          core_rsp_valid = 1'b1;
          core_quotient  = cm_q;
          core_remainder = cm_r;
        end else begin
          cm_cnt--;
        end
      end
      if (!cm_busy) core_ready = !stall_req && ($urandom_range(0, 3) != 0);
    end
  end

  always begin
    @(posedge clk);
    #1;
    out_ready = !hold_out && ($urandom_range(0, 3) != 0);
  end

  // Monitor: result scoreboard plus stability of held outputs
  bit          p_ch = 1'b0;
  bit          p_oh = 1'b0;
  logic [31:0] p_dvd, p_dvs, p_res;
  logic [4:0]  p_tag;
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst) begin
      p_ch = 1'b0;
      p_oh = 1'b0;
    end else begin
      if (core_valid) check("in_ready_busy", 64'(in_ready), 64'd0);
      if (p_ch) begin
        check("hold_dividend", 64'(core_dividend), 64'(p_dvd));
        check("hold_divisor", 64'(core_divisor), 64'(p_dvs));
      end
      p_ch  = core_valid && !core_ready;
      p_dvd = core_dividend;
      p_dvs = core_divisor;
      if (p_oh) begin
        check("hold_result", 64'(out_result), 64'(p_res));
        check("hold_tag", 64'(out_tag), 64'(p_tag));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(out_result), 64'(e[31:0]));
          check("tag", 64'(out_tag), 64'(e[36:32]));
        end
      end
      p_oh  = out_valid && !out_ready;
      p_res = out_result;
      p_tag = out_tag;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_core_valid", 64'(core_valid), 64'd0);
    check("rst_rsp_ready", 64'(core_rsp_ready), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_dividend", 64'(core_dividend), 64'd0);
    check("rst_divisor", 64'(core_divisor), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    run(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run(2'd3, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run(2'd1, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run(2'd0, 32'd5, 32'd0, 5'd7);
    run(2'd2, 32'd5, 32'd0, 5'd8);
    run(2'd0, MINV, 32'hFFFF_FFFF, 5'd9);
    run(2'd2, MINV, 32'hFFFF_FFFF, 5'd10);
    run(2'd0, MINV, 32'd3, 5'd11);
    run(2'd2, 32'd17, 32'hFFFF_FFFB, 5'd12);

    // Backpressure on both the core request and the result
    stall_req = 1'b1;
    hold_out  = 1'b1;
    @(posedge clk);
    #1;
    send(2'd0, 32'd1000, 32'hFFFF_FFFD, 5'd21);
    in_valid = 1'b1;
    in_op    = 2'd1;
    in_a     = 32'd9;
    in_b     = 32'd2;
    in_tag   = 5'd22;
    wait_neg("core_valid_timeout", core_valid);
    repeat (3) begin
      @(negedge clk);
      check("stall_core_valid", 64'(core_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    stall_req = 1'b0;
    wait_neg("out_valid_timeout", out_valid);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hold_out = 1'b0;
    drain();

    // Reset while waiting on the core
    lat_cfg = 20;
    send(2'd1, 32'd1000, 32'd7, 5'd1);
    wait_neg("wait_state_timeout", core_rsp_ready);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mag_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_core_valid", 64'(core_valid), 64'd0);
    check("mid_rst_rsp_ready", 64'(core_rsp_ready), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    lat_cfg = -1;
    run(2'd1, 32'd100, 32'd7, 5'd30);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      send(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(),
           5'($urandom_range(0, 31)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
